ex_mem_stage: RTL and testbench

Pipeline stage directly downstream of the execute ALU. It registers one ALU result bundle per transaction and performs the resulting action:
- register writeback for arithmetic ops
- data-memory store (CP) or load (GP) over a req/ack handshake
- branch redirect (B, BEG)

While a memory access is outstanding, the stage drops in_ready and the upstream pipeline stalls.

---
 rtl/ex_mem_stage.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// Purpose:
//   Pipeline stage directly after the execute ALU. Each accepted ALU bundle
//   is registered and turned into exactly one action:
//     - a one-cycle register writeback (arithmetic opcodes 1,2,3,4,5,9,12),
//     - a one-cycle branch redirect pulse (opcodes 7 = B, 8 = BEG),
//     - a data-memory store (opcode 6 = CP) over a req/ack handshake,
//     - a data-memory load (opcode 10 = GP) followed by a writeback cycle.
//   While a memory access is outstanding in_ready is low and upstream stalls.
//
// Parameters:
//   ADDR_W  : memory address / branch target width
//   REG_W   : register-file index width
//   TIMEOUT : memory wait cycles before abort (only with MEM_TIMEOUT_EN)
//
// Optional feature macro:
//   MEM_TIMEOUT_EN : when defined, a wait counter aborts a memory access that
//                    has not been acknowledged after TIMEOUT cycles and pulses
//                    mem_err. When undefined, mem_err is constant 0 and the
//                    stage waits for mem_ack indefinitely.
//
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready : upstream handshake (in_ready = IDLE && !rst)
//   opcode, rd_out, rd_mem, alu_result, mem_result, mem_out,
//   branch_result, wr_enable : ALU result bundle
//   mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata : memory port
//   wb_valid, wb_addr, wb_data : register writeback strobe
//   br_taken, br_target        : branch redirect pulse
//   instr_count                : retired (accepted) bundle counter
//   mem_err                    : timeout abort pulse
// ---------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [31:0]       rd_out,
  input  logic [31:0]       rd_mem,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       mem_result,
  input  logic [31:0]       mem_out,
  input  logic [31:0]       branch_result,
  input  logic              wr_enable,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_addr,
  output logic [31:0]       wb_data,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target,
  output logic [31:0]       instr_count,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    LOAD_WB  = 2'd2
  } state_e;

  state_e            state_q,       state_d;
  logic              mem_req_q,     mem_req_d;
  logic              mem_we_q,      mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [31:0]       mem_wdata_q,   mem_wdata_d;
  logic              wb_valid_q,    wb_valid_d;
  logic [REG_W-1:0]  wb_addr_q,     wb_addr_d;
  logic [31:0]       wb_data_q,     wb_data_d;
  logic              br_taken_q,    br_taken_d;
  logic [ADDR_W-1:0] br_target_q,   br_target_d;
  logic [31:0]       instr_count_q, instr_count_d;
  logic [REG_W-1:0]  ld_reg_q,      ld_reg_d;
  logic              mem_err_q,     mem_err_d;
  logic              accept;

`ifdef MEM_TIMEOUT_EN
  // At least 8 bits, wider only if TIMEOUT needs it.
  localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Upper operand bits that this stage never looks at.
  logic unused_bits;
`ifdef MEM_TIMEOUT_EN
  assign unused_bits = ^{rd_out[31:REG_W], rd_mem[31:ADDR_W], mem_out[31:ADDR_W]};
`else
  assign unused_bits = ^{rd_out[31:REG_W], rd_mem[31:ADDR_W], mem_out[31:ADDR_W],
                         32'(TIMEOUT)};
`endif

  // in_ready is the only combinational output: it must fall in the reset
  // cycle itself so nothing is accepted while the stage is being cleared.
  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Next-state and next-output logic. Pulse outputs default to 0 every cycle;
  // data outputs hold their last value until a new bundle overwrites them.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    wb_valid_d    = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    br_taken_d    = 1'b0;
    br_target_d   = br_target_q;
    instr_count_d = instr_count_q;
    ld_reg_d      = ld_reg_q;
    mem_err_d     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          instr_count_d = instr_count_q + 32'd1;
          case (opcode)
            5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd12: begin
              if (wr_enable) begin
                wb_valid_d = 1'b1;
                wb_addr_d  = rd_out[REG_W-1:0];
                wb_data_d  = alu_result;
              end
            end
            5'd7, 5'd8: begin
              br_taken_d  = (branch_result != 32'd0);
              br_target_d = branch_result[ADDR_W-1:0];
            end
            5'd6: begin
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = rd_mem[ADDR_W-1:0];
              mem_wdata_d = mem_result;
              state_d     = MEM_WAIT;
`ifdef MEM_TIMEOUT_EN
              wait_cnt_d  = '0;
`endif
            end
            5'd10: begin
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = mem_out[ADDR_W-1:0];
              // The load destination is latched now because upstream moves
              // on once the stage returns to IDLE.
              ld_reg_d   = rd_mem[REG_W-1:0];
              state_d    = MEM_WAIT;
`ifdef MEM_TIMEOUT_EN
              wait_cnt_d = '0;
`endif
            end
            default: begin
            end
          endcase
        end
      end

      MEM_WAIT: begin
        // mem_ack only counts while a request is actually on the bus; this
        // also covers the zero-wait case where ack arrives in the first
        // request cycle.
        if (mem_ack && mem_req_q) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d = IDLE;
          end else begin
            wb_valid_d = 1'b1;
            wb_addr_d  = ld_reg_q;
            wb_data_d  = mem_rdata;
            state_d    = LOAD_WB;
          end
        end
`ifdef MEM_TIMEOUT_EN
        // The count reaches TIMEOUT on this edge, so the access is dropped
        // after exactly TIMEOUT unacknowledged wait cycles.
        else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end

      LOAD_WB: begin
        // wb_valid is high during this cycle; it was set on the ack edge.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset. Clearing mem_req and
  // returning to IDLE is what makes any late mem_ack after reset harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      br_taken_q    <= 1'b0;
      br_target_q   <= '0;
      instr_count_q <= '0;
      ld_reg_q      <= '0;
      mem_err_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      br_taken_q    <= br_taken_d;
      br_target_q   <= br_target_d;
      instr_count_q <= instr_count_d;
      ld_reg_q      <= ld_reg_d;
      mem_err_q     <= mem_err_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
`endif
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign br_taken    = br_taken_q;
  assign br_target   = br_target_q;
  assign instr_count = instr_count_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_err     = mem_err_q;
`else
  assign mem_err     = 1'b0;
  logic unused_err;
  assign unused_err  = mem_err_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Self-checking bench for ex_mem_stage. Single-cycle opcodes are driven from
// a table of vectors with hand-computed expected outputs; memory accesses,
// reset during an access and the optional timeout are hand-written sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned TIMEOUT = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        opcode;
  logic [31:0]       rd_out;
  logic [31:0]       rd_mem;
  logic [31:0]       alu_result;
  logic [31:0]       mem_result;
  logic [31:0]       mem_out;
  logic [31:0]       branch_result;
  logic              wr_enable;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_addr;
  logic [31:0]       wb_data;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [31:0]       instr_count;
  logic              mem_err;

  int          numChecks;
  int          numFails;
  logic [31:0] expCount;

  ex_mem_stage #(
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .rd_out       (rd_out),
    .rd_mem       (rd_mem),
    .alu_result   (alu_result),
    .mem_result   (mem_result),
    .mem_out      (mem_out),
    .branch_result(branch_result),
    .wr_enable    (wr_enable),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .instr_count  (instr_count),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if the sequences lose their way.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [4:0]  opcode;
    logic [31:0] rd_out;
    logic [31:0] alu_result;
    logic [31:0] branch_result;
    logic        wr_enable;
    logic        exp_wb;
    logic [4:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic        exp_br;
    logic [15:0] exp_br_target;
  } vec_t;

  vec_t vecs[11];

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid      = 1'b1;
    opcode        = v.opcode;
    rd_out        = v.rd_out;
    alu_result    = v.alu_result;
    branch_result = v.branch_result;
    wr_enable     = v.wr_enable;
  endtask

  // Drives a memory bundle for one accept cycle.
  task automatic applyMemOp(input logic [4:0] op, input logic [31:0] rdMem,
                            input logic [31:0] memRes, input logic [31:0] memOut);
    in_valid   = 1'b1;
    opcode     = op;
    rd_mem     = rdMem;
    mem_result = memRes;
    mem_out    = memOut;
    wr_enable  = 1'b0;
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    expCount  = 32'd0;

    rst = 1'b1; in_valid = 1'b0; opcode = 5'd0; rd_out = '0; rd_mem = '0;
    alu_result = '0; mem_result = '0; mem_out = '0; branch_result = '0;
    wr_enable = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

    //            op     rd_out        alu_result    branch_result  we    wb    wbA    wbD           br    brT
    vecs[0]  = '{5'd5,  32'd3,        32'h0000_002A, 32'd0,         1'b1, 1'b1, 5'd3,  32'h0000_002A, 1'b0, 16'h0};
    vecs[1]  = '{5'd1,  32'd31,       32'hFFFF_FFFF, 32'd0,         1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 16'h0};
    vecs[2]  = '{5'd12, 32'h25,       32'h1234_5678, 32'd0,         1'b1, 1'b1, 5'd5,  32'h1234_5678, 1'b0, 16'h0};
    vecs[3]  = '{5'd9,  32'd4,        32'h0000_0055, 32'd0,         1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 16'h0};
    vecs[4]  = '{5'd8,  32'd0,        32'd0,         32'h0000_0040, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 16'h0040};
    vecs[5]  = '{5'd8,  32'd0,        32'd0,         32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 16'h0};
    vecs[6]  = '{5'd7,  32'd0,        32'd0,         32'h0001_ABCD, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 16'hABCD};
    vecs[7]  = '{5'd0,  32'd2,        32'h0000_0011, 32'h0000_0080, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 16'h0};
    vecs[8]  = '{5'd11, 32'd6,        32'h0000_0022, 32'h0000_0090, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 16'h0};
    vecs[9]  = '{5'd31, 32'd8,        32'h0000_0033, 32'd0,         1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 16'h0};
    vecs[10] = '{5'd3,  32'd7,        32'h0000_0005, 32'd0,         1'b1, 1'b1, 5'd7,  32'h0000_0005, 1'b0, 16'h0};

    // Reset for two cycles; in_ready must be low while rst is high.
    nextCycle();
    checkOutput("in_ready during reset", {31'd0, in_ready}, 32'd0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("in_ready after reset", {31'd0, in_ready}, 32'd1);
    checkOutput("mem_req after reset", {31'd0, mem_req}, 32'd0);
    checkOutput("wb_valid after reset", {31'd0, wb_valid}, 32'd0);
    checkOutput("br_taken after reset", {31'd0, br_taken}, 32'd0);
    checkOutput("mem_err after reset", {31'd0, mem_err}, 32'd0);
    checkOutput("instr_count after reset", instr_count, 32'd0);
    @(negedge clk);

    // Single-cycle opcodes from the table, each followed by an idle cycle
    // that confirms the pulses last exactly one cycle.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      nextCycle();
      in_valid = 1'b0;
      expCount = expCount + 32'd1;
      checkOutput($sformatf("vec%0d wb_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].exp_wb});
      if (vecs[i].exp_wb) begin
        checkOutput($sformatf("vec%0d wb_addr", i), {27'd0, wb_addr}, {27'd0, vecs[i].exp_wb_addr});
        checkOutput($sformatf("vec%0d wb_data", i), wb_data, vecs[i].exp_wb_data);
      end
      checkOutput($sformatf("vec%0d br_taken", i), {31'd0, br_taken}, {31'd0, vecs[i].exp_br});
      if (vecs[i].exp_br) begin
        checkOutput($sformatf("vec%0d br_target", i), {16'd0, br_target}, {16'd0, vecs[i].exp_br_target});
      end
      checkOutput($sformatf("vec%0d instr_count", i), instr_count, expCount);
      checkOutput($sformatf("vec%0d mem_req", i), {31'd0, mem_req}, 32'd0);
      nextCycle();
      checkOutput($sformatf("vec%0d wb_valid pulse end", i), {31'd0, wb_valid}, 32'd0);
      checkOutput($sformatf("vec%0d br_taken pulse end", i), {31'd0, br_taken}, 32'd0);
      checkOutput($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
    end

    // mem_ack with no request outstanding must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    nextCycle();
    mem_ack = 1'b0;
    checkOutput("stray ack mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("stray ack wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("stray ack in_ready", {31'd0, in_ready}, 32'd1);

    // Store, acknowledged in the third request cycle.
    applyMemOp(5'd6, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0999);
    nextCycle();
    in_valid = 1'b0;
    expCount = expCount + 32'd1;
    for (int c = 1; c <= 3; c++) begin
      checkOutput($sformatf("store c%0d mem_req", c), {31'd0, mem_req}, 32'd1);
      checkOutput($sformatf("store c%0d mem_we", c), {31'd0, mem_we}, 32'd1);
      checkOutput($sformatf("store c%0d mem_addr", c), {16'd0, mem_addr}, 32'h0000_0010);
      checkOutput($sformatf("store c%0d mem_wdata", c), mem_wdata, 32'hDEAD_BEEF);
      checkOutput($sformatf("store c%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      checkOutput($sformatf("store c%0d wb_valid", c), {31'd0, wb_valid}, 32'd0);
      if (c == 3) mem_ack = 1'b1;
      nextCycle();
    end
    mem_ack = 1'b0;
    checkOutput("store done mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("store done wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("store done in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("store instr_count", instr_count, expCount);

    // Load with a zero-wait memory: ack in the first request cycle.
    applyMemOp(5'd10, 32'd7, 32'd0, 32'h0000_0020);
    nextCycle();
    in_valid = 1'b0;
    expCount = expCount + 32'd1;
    checkOutput("load mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("load mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("load mem_addr", {16'd0, mem_addr}, 32'h0000_0020);
    checkOutput("load in_ready", {31'd0, in_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
    nextCycle();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checkOutput("load wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("load wb_addr", {27'd0, wb_addr}, 32'd7);
    checkOutput("load wb_data", wb_data, 32'h0000_1234);
    checkOutput("load wb in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("load wb mem_req", {31'd0, mem_req}, 32'd0);
    nextCycle();
    checkOutput("load done wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("load done in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("load instr_count", instr_count, expCount);

    // Reset in the middle of a load, followed by a late ack.
    applyMemOp(5'd10, 32'd9, 32'd0, 32'h0000_0030);
    nextCycle();
    in_valid = 1'b0;
    checkOutput("rst-load mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    nextCycle();
    checkOutput("rst-load in_ready in reset", {31'd0, in_ready}, 32'd0);
    checkOutput("rst-load mem_req in reset", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
    nextCycle();
    mem_ack = 1'b0;
    expCount = 32'd0;
    checkOutput("rst-load wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst-load mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst-load in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst-load instr_count", instr_count, expCount);
    nextCycle();
    checkOutput("rst-load wb_valid later", {31'd0, wb_valid}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Unacknowledged load: aborted after TIMEOUT wait cycles, no writeback.
    applyMemOp(5'd10, 32'd12, 32'd0, 32'h0000_0044);
    nextCycle();
    in_valid = 1'b0;
    expCount = expCount + 32'd1;
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("timeout c%0d mem_req", c), {31'd0, mem_req}, 32'd1);
      checkOutput($sformatf("timeout c%0d mem_err", c), {31'd0, mem_err}, 32'd0);
      nextCycle();
    end
    checkOutput("timeout mem_err", {31'd0, mem_err}, 32'd1);
    checkOutput("timeout mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("timeout in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("timeout wb_valid", {31'd0, wb_valid}, 32'd0);
    nextCycle();
    checkOutput("timeout mem_err pulse end", {31'd0, mem_err}, 32'd0);
    checkOutput("timeout wb_valid later", {31'd0, wb_valid}, 32'd0);
    checkOutput("timeout instr_count", instr_count, expCount);
`else
    // Without the timeout feature a store waits as long as needed.
    applyMemOp(5'd6, 32'h0000_0050, 32'hCAFE_F00D, 32'd0);
    nextCycle();
    in_valid = 1'b0;
    expCount = expCount + 32'd1;
    for (int c = 1; c <= 10; c++) begin
      checkOutput($sformatf("long wait c%0d mem_req", c), {31'd0, mem_req}, 32'd1);
      checkOutput($sformatf("long wait c%0d mem_err", c), {31'd0, mem_err}, 32'd0);
      if (c == 10) mem_ack = 1'b1;
      nextCycle();
    end
    mem_ack = 1'b0;
    checkOutput("long wait done mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("long wait done in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("long wait instr_count", instr_count, expCount);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
